// File: rtl/scan_ctrl8_pkg.sv
// Shared definitions for the display scan controller: state encoding and default timing.
package scan_ctrl8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  localparam int unsigned DIV_DEFAULT   = 50000;
  localparam int unsigned BLANK_DEFAULT = 4;
  localparam int unsigned POS_N         = 8;
  localparam int unsigned SEL_W         = 3;
  localparam int unsigned NIB_W         = 4;

endpackage

// File: rtl/scan_next_idx.sv
// Circular priority search: first set mask bit strictly after cur (cur itself is checked last).
module scan_next_idx
  import scan_ctrl8_pkg::*;
(
  input  logic [SEL_W-1:0] cur,
  input  logic [POS_N-1:0] mask,
  output logic [SEL_W-1:0] nxt_c,
  output logic             wrap_c,
  output logic             none_c
);

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    logic [SEL_W-1:0] idx;
    idx   = '0;
    nxt_c = cur;
    for (int i = POS_N; i >= 1; i--) begin
      idx = cur + SEL_W'(i);
      if (mask[idx]) nxt_c = idx;
    end
    none_c = (mask == '0);
    wrap_c = !none_c && (nxt_c <= cur);
  end

endmodule

// File: rtl/scan_ctrl8.sv
// Time-multiplexed 8-position display scanner with per-slot blanking and frame pulse.
module scan_ctrl8
  import scan_ctrl8_pkg::*;
#(
  parameter int unsigned DIV   = DIV_DEFAULT,
  parameter int unsigned BLANK = BLANK_DEFAULT
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic [POS_N-1:0]         i_mask,
  input  logic [POS_N*NIB_W-1:0]   i_digits,
  output logic [SEL_W-1:0]         o_sel,
  output logic [NIB_W-1:0]         o_nib,
  output logic                     o_blank,
  output logic                     o_frame
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_d;
  logic [NIB_W-1:0] nib_d;
  logic             blank_d;
  logic             frame_d;

  logic [SEL_W-1:0] search_cur;
  logic [SEL_W-1:0] nxt_idx;
  logic             nxt_wrap;
  logic             nxt_none;

  // From idle, searching after position 7 yields the lowest set bit.
  assign search_cur = (state_q == ST_IDLE) ? SEL_W'(POS_N - 1) : o_sel;

  scan_next_idx u_next (
    .cur    (search_cur),
    .mask   (i_mask),
    .nxt_c  (nxt_idx),
    .wrap_c (nxt_wrap),
    .none_c (nxt_none)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = o_sel;
    nib_d   = o_nib;
    blank_d = o_blank;
    frame_d = 1'b0;

    if (!i_en) begin
      state_d = ST_IDLE;
      blank_d = 1'b1;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          blank_d = 1'b1;
          if (!nxt_none) begin
            state_d = ST_BLANK;
            sel_d   = nxt_idx;
            cnt_d   = '0;
          end
        end
        ST_BLANK: begin
          blank_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            blank_d = 1'b0;
            nib_d   = i_digits[{o_sel, 2'b00} +: NIB_W];
          end
        end
        ST_SHOW: begin
          blank_d = 1'b0;
          if (cnt_q == DIV_LAST) begin
            cnt_d   = '0;
            blank_d = 1'b1;
            if (nxt_none) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_BLANK;
              sel_d   = nxt_idx;
              frame_d = nxt_wrap;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          blank_d = 1'b1;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      o_sel   <= '0;
      o_nib   <= '0;
      o_blank <= 1'b1;
      o_frame <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_sel   <= sel_d;
      o_nib   <= nib_d;
      o_blank <= blank_d;
      o_frame <= frame_d;
    end
  end

endmodule

// File: tb/tb_scan_ctrl8.sv
// Scoreboard bench for scan_ctrl8: reference model pushes expected outputs, monitor pops and compares.
module tb_scan_ctrl8;
  import scan_ctrl8_pkg::*;

  localparam int unsigned T_DIV   = 8;
  localparam int unsigned T_BLANK = 2;

  typedef struct packed {
    logic [2:0] sel;
    logic [3:0] nib;
    logic       blank;
    logic       frame;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic [7:0]  mask = 8'hFF;
  logic [31:0] digits = 32'h0;
  logic [2:0]  o_sel;
  logic [3:0]  o_nib;
  logic        o_blank;
  logic        o_frame;

  logic [2:0]  u_cur = 3'd0;
  logic [7:0]  u_mask = 8'd0;
  logic [2:0]  u_nxt;
  logic        u_wrap;
  logic        u_none;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  bit   done = 1'b0;

  always #5 clk = ~clk;

  scan_ctrl8 #(.DIV(T_DIV), .BLANK(T_BLANK)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_mask   (mask),
    .i_digits (digits),
    .o_sel    (o_sel),
    .o_nib    (o_nib),
    .o_blank  (o_blank),
    .o_frame  (o_frame)
  );

  scan_next_idx u_nx (
    .cur    (u_cur),
    .mask   (u_mask),
    .nxt_c  (u_nxt),
    .wrap_c (u_wrap),
    .none_c (u_none)
  );

  // First enabled position strictly after cur, going round the ring of 8.
  function automatic logic [2:0] next_after(input logic [2:0] cur, input logic [7:0] m);
    for (int k = 1; k <= 8; k++) begin
      if (m[(int'(cur) + k) % 8]) return 3'((int'(cur) + k) % 8);
    end
    return cur;
  endfunction

  // Reference model in terms of "active" and position within the slot.
  bit         m_act = 1'b0;
  logic [2:0] m_sel = 3'd0;
  logic [3:0] m_nib = 4'd0;
  logic       m_blank = 1'b1;
  logic       m_frame = 1'b0;
  int         m_pos = 0;

  always @(posedge clk) begin
    logic [2:0] ns;
    ns = 3'd0;
    m_frame = 1'b0;
    if (rst) begin
      m_act = 1'b0; m_sel = 3'd0; m_nib = 4'd0; m_pos = 0; m_blank = 1'b1;
    end else if (!en) begin
      m_act = 1'b0; m_pos = 0; m_blank = 1'b1;
    end else if (!m_act) begin
      m_blank = 1'b1;
      if (mask != 8'd0) begin
        m_act = 1'b1;
        m_sel = next_after(3'd7, mask);
        m_pos = 0;
      end
    end else begin
      m_pos = m_pos + 1;
      if (m_pos == int'(T_DIV)) begin
        m_pos = 0;
        if (mask == 8'd0) begin
          m_act = 1'b0;
        end else begin
          ns = next_after(m_sel, mask);
          m_frame = (ns <= m_sel);
          m_sel = ns;
        end
      end
      if (m_act && m_pos == int'(T_BLANK)) m_nib = digits[4*m_sel +: 4];
      m_blank = !m_act || (m_pos < int'(T_BLANK));
    end
    exp_q.push_back('{sel: m_sel, nib: m_nib, blank: m_blank, frame: m_frame});
  end

  // Monitor: one registered output set per cycle, compared away from the edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (o_sel !== e.sel || o_nib !== e.nib || o_blank !== e.blank || o_frame !== e.frame) begin
          errors++;
          $display("FAIL outputs t=%0t got sel=%0d nib=%h blank=%b frame=%b want sel=%0d nib=%h blank=%b frame=%b",
                   $time, o_sel, o_nib, o_blank, o_frame, e.sel, e.nib, e.blank, e.frame);
        end
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [2:0] w_nxt;
    logic       w_none;
    logic       w_wrap;

    // Standalone exhaustive check of the search block.
    for (int c = 0; c < 8; c++) begin
      for (int m = 0; m < 256; m++) begin
        u_cur  = 3'(c);
        u_mask = 8'(m);
        #1;
        w_none = (m == 0);
        w_nxt  = next_after(3'(c), 8'(m));
        w_wrap = !w_none && (w_nxt <= 3'(c));
        checks++;
        if (u_none !== w_none || (!w_none && (u_nxt !== w_nxt || u_wrap !== w_wrap))) begin
          errors++;
          $display("FAIL next_idx cur=%0d mask=%h got nxt=%0d wrap=%b none=%b want nxt=%0d wrap=%b none=%b",
                   c, m, u_nxt, u_wrap, u_none, w_nxt, w_wrap, w_none);
        end
      end
    end

    // Reset held with enable high.
    @(negedge clk);
    rst = 1'b1; en = 1'b1; mask = 8'hFF; digits = 32'h76543210;
    run(3);
    rst = 1'b0;
    run(70);

    // Sparse mask, then a mid-slot mask change.
    mask = 8'h24;
    run(45);
    mask = 8'h80;
    run(20);

    // Single position.
    mask = 8'h01;
    run(30);

    // Disable mid-show, re-enable, then an empty mask at a boundary.
    mask = 8'hFF;
    run(13);
    en = 1'b0;
    run(3);
    en = 1'b1;
    run(12);
    mask = 8'h00;
    run(12);
    mask = 8'h5A;
    run(10);

    // Digits changing during show, and a mid-slot reset.
    digits = 32'hFEDCBA98;
    run(3);
    digits = 32'h13579BDF;
    run(9);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(20);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 3))
          0: mask = 8'h00;
          1: mask = 8'(1 << $urandom_range(0, 7));
          default: mask = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 4) == 0) digits = $urandom;
      run(1);
    end

    @(posedge clk);
    #2;
    done = 1'b1;
    checks++;
    if (exp_q.size() > 1) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want at most 1", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
